// File: rtl/uart_receiver.sv
// UART receiver: 2-flop synchronized serial input, BCLK-oversampled
// start/data/stop sampling, framing-error flag and one-cycle done pulse.
module uart_receiver #(
  parameter int unsigned width      = 8,
  parameter int unsigned oversample = 16
) (
  input  logic             clk,
  input  logic             arst,
  input  logic             rst,
  input  logic             BCLK,
  input  logic             rx_en,
  input  logic             rx_data,
  output logic [width-1:0] data,
  output logic             done,
  output logic             busy,
  output logic             err
);

  localparam int unsigned tick_w = $clog2(oversample);
  localparam int unsigned bit_w  = $clog2(width + 1);

  localparam logic [tick_w-1:0] tick_mid  = tick_w'(oversample / 2 - 1);
  localparam logic [tick_w-1:0] tick_last = tick_w'(oversample - 1);
  localparam logic [bit_w-1:0]  bit_last  = bit_w'(width - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [tick_w-1:0]  tick_q, tick_d;
  logic [bit_w-1:0]   bit_q, bit_d;
  logic [width-1:0]   shift_q, shift_d;
  logic [width-1:0]   data_d;
  logic               err_d;
  logic               done_d;
  logic               busy_d;
  logic [1:0]         sync_q;
  logic               rx_s;

  assign rx_s = sync_q[1];

  // Two-flop synchronizer for the asynchronous serial line, idling high
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      sync_q <= 2'b11;
    end else if (rst) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], rx_data};
    end
  end

  // Next-state and datapath updates; counters only move on BCLK cycles
  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data;
    err_d   = err;
    case (state_q)
      IDLE: begin
        if (BCLK && rx_en && !rx_s) begin
          state_d = START;
          tick_d  = '0;
        end
      end
      START: begin
        if (BCLK) begin
          if (tick_q == tick_mid) begin
            if (!rx_s) begin
              state_d = DATA;
              tick_d  = '0;
              bit_d   = '0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            tick_d = tick_q + tick_w'(1);
          end
        end
      end
      DATA: begin
        if (BCLK) begin
          if (tick_q == tick_last) begin
            shift_d = {rx_s, shift_q[width-1:1]};
            bit_d   = bit_q + bit_w'(1);
            tick_d  = '0;
            if (bit_q == bit_last) begin
              state_d = STOP;
            end
          end else begin
            tick_d = tick_q + tick_w'(1);
          end
        end
      end
      STOP: begin
        if (BCLK) begin
          if (tick_q == tick_last) begin
            if (rx_s) begin
              data_d = shift_q;
              err_d  = 1'b0;
            end else begin
              err_d  = 1'b1;
            end
            tick_d  = '0;
            state_d = DONE;
          end else begin
            tick_d = tick_q + tick_w'(1);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    done_d = (state_d == DONE);
    busy_d = (state_d == START) || (state_d == DATA) || (state_d == STOP);
  end

  // State and output registers; busy/done registered from the next state
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q <= IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data    <= '0;
      err     <= 1'b0;
      done    <= 1'b0;
      busy    <= 1'b0;
    end else if (rst) begin
      state_q <= IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data    <= '0;
      err     <= 1'b0;
      done    <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data    <= data_d;
      err     <= err_d;
      done    <= done_d;
      busy    <= busy_d;
    end
  end

endmodule

// File: tb/tb_uart_receiver.sv
// Randomized bench for uart_receiver against a frame-level reference model.
module tb_uart_receiver;

  localparam int unsigned width      = 8;
  localparam int unsigned oversample = 16;
  localparam int unsigned bclk_div   = 4;
  localparam int unsigned busy_len   = (oversample / 2 + oversample * (width + 1)) * bclk_div;

  logic             clk = 1'b0;
  logic             arst;
  logic             rst;
  logic             BCLK;
  logic             rx_en;
  logic             rx_data;
  logic [width-1:0] data;
  logic             done;
  logic             busy;
  logic             err;

  typedef struct {
    logic [width-1:0] d;
    logic             e;
  } rec_t;

  rec_t got_q[$];
  rec_t exp_q[$];

  int n_checks = 0;
  int n_pass   = 0;
  int dbl_done = 0;
  int busy_cycles = 0;
  bit busy_seen = 1'b0;
  logic prev_done = 1'b0;

  logic [width-1:0] m_data;
  logic             m_err;

  uart_receiver #(.width(width), .oversample(oversample)) dut (
    .clk     (clk),
    .arst    (arst),
    .rst     (rst),
    .BCLK    (BCLK),
    .rx_en   (rx_en),
    .rx_data (rx_data),
    .data    (data),
    .done    (done),
    .busy    (busy),
    .err     (err)
  );

  always #5 clk = ~clk;

  // Oversample enable: one clk wide every bclk_div cycles
  initial begin
    BCLK = 1'b0;
    forever begin
      repeat (bclk_div - 1) @(posedge clk);
      #1 BCLK = 1'b1;
      @(posedge clk);
      #1 BCLK = 1'b0;
    end
  end

  // Capture every done pulse with the outputs it presents
  always @(negedge clk) begin
    rec_t r;
    if (done) begin
      r.d = data;
      r.e = err;
      got_q.push_back(r);
      if (prev_done) dbl_done++;
    end
    prev_done = done;
    if (busy) begin
      busy_cycles++;
      busy_seen = 1'b1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic wait_bclk();
    do @(posedge clk); while (BCLK !== 1'b1);
  endtask

  task automatic hold(input int n);
    repeat (n) wait_bclk();
  endtask

  task automatic send_bit(input logic v);
    #1 rx_data = v;
    hold(oversample);
  endtask

  task automatic send_frame(input logic [width-1:0] b, input logic stop, input bit drop_en);
    send_bit(1'b0);
    if (drop_en) rx_en = 1'b0;
    for (int i = 0; i < int'(width); i++) send_bit(b[i]);
    send_bit(stop);
    #1 rx_data = 1'b1;
  endtask

  // Reference: what a frame should leave behind, from the frame's own bits
  task automatic model_frame(input logic [width-1:0] b, input logic stop, input logic en);
    rec_t r;
    if (!en) return;
    if (stop) begin
      m_data = b;
      m_err  = 1'b0;
    end else begin
      m_err = 1'b1;
    end
    r.d = m_data;
    r.e = m_err;
    exp_q.push_back(r);
  endtask

  task automatic idle_gap(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic run_frame(input logic [width-1:0] b, input logic stop, input logic en, input bit drop_en);
    rx_en = en;
    idle_gap($urandom_range(1, 20));
    model_frame(b, stop, en);
    send_frame(b, stop, drop_en);
  endtask

  task automatic settle(input string tag);
    int n;
    hold(24);
    check({tag, "_ndone"}, 32'(got_q.size()), 32'(exp_q.size()));
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check({tag, "_data"}, 32'(got_q[i].d), 32'(exp_q[i].d));
      check({tag, "_err"},  32'(got_q[i].e), 32'(exp_q[i].e));
    end
    got_q.delete();
    exp_q.delete();
    check({tag, "_data_out"}, 32'(data), 32'(m_data));
    check({tag, "_err_out"},  32'(err),  32'(m_err));
    check({tag, "_busy_idle"}, 32'(busy), 32'(0));
  endtask

  initial begin
    logic [width-1:0] b;
    arst    = 1'b1;
    rst     = 1'b0;
    rx_en   = 1'b0;
    rx_data = 1'b1;
    m_data  = '0;
    m_err   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_data", 32'(data), 32'(0));
    check("rst_done", 32'(done), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_err",  32'(err),  32'(0));
    arst = 1'b0;
    idle_gap(5);

    // Valid 0xA5 frame, busy length measured
    busy_cycles = 0;
    run_frame(8'hA5, 1'b1, 1'b1, 1'b0);
    settle("a5");
    check("a5_busy_len", 32'(busy_cycles), 32'(busy_len));

    // False start: low for 4 BCLK only
    rx_en = 1'b1;
    idle_gap(7);
    #1 rx_data = 1'b0;
    hold(4);
    #1 rx_data = 1'b1;
    settle("false_start");

    // Framing error keeps previous data
    run_frame(8'h3C, 1'b0, 1'b1, 1'b0);
    settle("ferr");

    // Receiver disabled: nothing happens
    busy_seen = 1'b0;
    run_frame(8'h55, 1'b1, 1'b0, 1'b0);
    settle("dis");
    check("dis_busy_seen", 32'(busy_seen), 32'(0));

    // rx_en dropped mid-frame does not abort
    run_frame(8'h6B, 1'b1, 1'b1, 1'b1);
    settle("drop_en");

    // Async reset during data bit 4
    rx_en = 1'b1;
    idle_gap(3);
    b = 8'h5A;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(b[i]);
    #1 rx_data = b[4];
    hold(8);
    check("arst_busy_before", 32'(busy), 32'(1));
    #3 arst = 1'b1;
    rx_data = 1'b1;
    #1;
    check("arst_data", 32'(data), 32'(0));
    check("arst_busy", 32'(busy), 32'(0));
    check("arst_err",  32'(err),  32'(0));
    check("arst_done", 32'(done), 32'(0));
    #10 arst = 1'b0;
    m_data = '0;
    m_err  = 1'b0;
    settle("arst");
    run_frame(8'h81, 1'b1, 1'b1, 1'b0);
    settle("post_arst");

    // Synchronous clear during a frame
    rx_en = 1'b1;
    idle_gap(2);
    b = 8'hC3;
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(b[i]);
    check("srst_busy_before", 32'(busy), 32'(1));
    rx_data = 1'b1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("srst_data", 32'(data), 32'(0));
    check("srst_busy", 32'(busy), 32'(0));
    rst = 1'b0;
    m_data = '0;
    m_err  = 1'b0;
    settle("srst");

    // Back-to-back frames with a single stop bit
    rx_en = 1'b1;
    idle_gap(9);
    model_frame(8'h00, 1'b1, 1'b1);
    send_frame(8'h00, 1'b1, 1'b0);
    model_frame(8'hFF, 1'b1, 1'b1);
    send_frame(8'hFF, 1'b1, 1'b0);
    settle("b2b");

    // Random frames
    for (int k = 0; k < 12; k++) begin
      run_frame(width'($urandom_range(0, 255)), ($urandom_range(0, 3) != 0),
                ($urandom_range(0, 4) != 0), 1'b0);
      settle("rnd");
    end

    check("done_single_cycle", 32'(dbl_done), 32'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_receiver.md
UART_RECEIVER -- requirements
Module: uart_receiver

Interface
REQ-001 Parameter width, default 8, meaning number of data bits per frame.
REQ-002 Parameter oversample, default 16, meaning BCLK ticks per bit period.
REQ-003 clk  input  1  system clock; all state updates on its rising edge.
REQ-004 arst  input  1  reset, asynchronous, active-high; clears all state immediately.
REQ-005 rst  input  1  synchronous clear, active-high; same effect as arst on the next clk edge.
REQ-006 BCLK  input  1  oversample enable, one clk cycle wide, oversample pulses per bit period.
REQ-007 rx_en  input  1  receive enable; sampled only in IDLE.
REQ-008 rx_data  input  1  asynchronous serial line; idle high, LSB first, 1 start, width data, 1 stop bit.
REQ-009 data  output  width  last received byte; held until the next valid frame.
REQ-010 done  output  1  one-clk pulse at end of every completed frame.
REQ-011 busy  output  1  high while a frame is in progress.
REQ-012 err  output  1  framing error flag for the most recent frame.

Function
REQ-013 rx_data SHALL pass through a 2-flop synchronizer, both flops reset to 1; all decisions use the synchronized value (rx_s).
REQ-014 FSM states SHALL be IDLE, START, DATA, STOP, DONE; a 4-bit tick counter and a bit counter advance only on cycles with BCLK=1.
REQ-015 IDLE: on BCLK=1 with rx_en=1 and rx_s=0, go to START with tick counter=0; otherwise remain; busy=0.
REQ-016 START: on the BCLK where tick counter = oversample/2-1 (7), if rx_s=0 go to DATA with tick counter=0 and bit counter=0, else return to IDLE (false start; no done, err unchanged).
REQ-017 DATA: on the BCLK where tick counter = oversample-1 (15), shift rx_s into the MSB of a width-bit shift register (LSB-first reception), increment bit counter, wrap tick counter to 0; after the width-th sample go to STOP.
REQ-018 STOP: on the BCLK where tick counter = 15, sample rx_s; if 1, load data from the shift register and set err=0; if 0, set err=1 and leave data unchanged; go to DONE in both cases.
REQ-019 DONE: done=1 for exactly one clk cycle, then unconditionally IDLE on the next clk (no BCLK qualification).
REQ-020 busy SHALL be 1 in START, DATA and STOP, and 0 in IDLE and DONE.
REQ-021 err SHALL hold its value until the next frame reaches STOP sampling.
REQ-022 rx_en deasserting mid-frame SHALL NOT abort the frame.
REQ-023 A new start edge is accepted starting from the first BCLK in IDLE after DONE (back-to-back frames with a single stop bit are supported).
REQ-024 Undefined state encodings SHALL return to IDLE on the next clk.
REQ-025 Latency: done asserts at most 2 clk after the stop-bit mid-sample BCLK.

Reset
REQ-026 On arst=1 (asynchronous) or rst=1 (synchronous), the block SHALL enter IDLE with data=0, done=0, busy=0, err=0, counters=0, shift register=0, and synchronizer flops=1.
REQ-027 Reset asserted mid-frame SHALL abandon the frame with no done pulse; reception resumes only on a fresh start bit after reset release.
REQ-028 arst SHALL take priority over rst, and rst over all functional behaviour.

Verification
REQ-029 Frame 0xA5 with valid stop, rx_en=1 -> data=0xA5, err=0, one done pulse, busy high for about 9.5 bit periods.
REQ-030 rx_data low for 4 BCLK ticks then high -> FSM returns to IDLE, no done, data and err unchanged.
REQ-031 Frame 0x3C with stop bit driven 0 -> done pulses, err=1, data keeps its previous value.
REQ-032 rx_en=0 with a valid 0x55 frame on the line -> no busy, no done, data unchanged.
REQ-033 arst pulse during data bit 4 of a frame -> outputs immediately at reset values, no done; the following 0x81 frame is received correctly.
REQ-034 Back-to-back frames 0x00 then 0xFF with one stop bit between them -> two done pulses, data=0x00 then 0xFF, err=0 both times.
